// File: rtl/core_sequencer_pkg.sv
// Shared encodings for the core sequencer: exception codes, FSM state encoding
// and the fixed-priority exception merge used in EXEC.
package core_sequencer_pkg;

   localparam int EXCEPTION_LEN = 4;
   typedef logic [EXCEPTION_LEN-1:0] excep_t;

   localparam excep_t EXCEP_OK           = 4'h0;
   localparam excep_t EXCEP_ILLEGAL_INST = 4'h2;
   localparam excep_t EXCEP_ENV_BREAK    = 4'h3;
   localparam excep_t EXCEP_BUS_TIMEOUT  = 4'hE;

   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_FETCH  = 3'd1,
      SEQ_EXEC   = 3'd2,
      SEQ_MEM    = 3'd3,
      SEQ_COMMIT = 3'd4,
      SEQ_HALT   = 3'd5,
      SEQ_TRAP   = 3'd6
   } seq_state_t;

   // Fetch faults are resolved before EXEC, so only decode and execute remain.
   function automatic excep_t pick_excep(input excep_t id_code, input excep_t ex_code);
      return (id_code != EXCEP_OK) ? id_code : ex_code;
   endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Down-counter bounding how long FETCH or MEM may wait for a done strobe.
// Loaded on clear; expired is high once the count has run down to zero.
module core_sequencer_wait_timer #(
   parameter int LOAD = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [7:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= 8'(LOAD);
      end else if (clear) begin
         count <= 8'(LOAD);
      end else if (enable && count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign expired = (count == 8'd0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch / exec / mem / commit stepping,
// exception merge, halt-resume on env break and sticky trap.
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     resume_In,
   input  logic                     fetchDone_In,
   input  logic [EXCEPTION_LEN-1:0] ifException_In,
   input  logic [EXCEPTION_LEN-1:0] idException_In,
   input  logic                     exMemReq_In,
   input  logic                     exMemDone_In,
   input  logic [EXCEPTION_LEN-1:0] exException_In,
   output logic                     fetchStart_Out,
   output logic                     execEnable_Out,
   output logic                     pcCommit_Out,
   output logic                     rdCommit_Out,
   output logic                     execLock_Out,
   output logic                     halted_Out,
   output logic                     trapped_Out,
   output logic [EXCEPTION_LEN-1:0] trapCause_Out,
   output logic [31:0]              retired_Out,
   output logic [31:0]              cycles_Out
);

   seq_state_t state, state_nxt;
   logic       halt_pending, halt_nxt;
   excep_t     cause_nxt;
   excep_t     resolve_code;
   logic       resolve_en;
   logic       timer_clear, timer_expired;
   logic [31:0] retired_cnt, cycles_cnt;

   core_sequencer_wait_timer #(.LOAD(MEM_TIMEOUT - 1)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .enable  (state == SEQ_FETCH || state == SEQ_MEM),
      .expired (timer_expired)
   );

   assign timer_clear = (state_nxt != state) &&
                        (state_nxt == SEQ_FETCH || state_nxt == SEQ_MEM);

   always_comb begin
      state_nxt    = state;
      halt_nxt     = halt_pending;
      cause_nxt    = trapCause_Out;
      resolve_code = EXCEP_OK;
      resolve_en   = 1'b0;
      case (state)
         SEQ_IDLE:   state_nxt = SEQ_FETCH;
         SEQ_FETCH: begin
            if (fetchDone_In) begin
               if (ifException_In == EXCEP_OK) begin
                  state_nxt = SEQ_EXEC;
               end else begin
                  resolve_en   = 1'b1;
                  resolve_code = ifException_In;
               end
            end else if (timer_expired) begin
               state_nxt = SEQ_TRAP;
               cause_nxt = EXCEP_BUS_TIMEOUT;
            end
         end
         SEQ_EXEC: begin
            resolve_code = pick_excep(idException_In, exException_In);
            if (resolve_code != EXCEP_OK) begin
               resolve_en = 1'b1;
            end else begin
               state_nxt = exMemReq_In ? SEQ_MEM : SEQ_COMMIT;
            end
         end
         SEQ_MEM: begin
            if (exMemDone_In) begin
               resolve_en   = 1'b1;
               resolve_code = exException_In;
            end else if (timer_expired) begin
               state_nxt = SEQ_TRAP;
               cause_nxt = EXCEP_BUS_TIMEOUT;
            end
         end
         SEQ_COMMIT: state_nxt = halt_pending ? SEQ_HALT : SEQ_FETCH;
         SEQ_HALT: begin
            if (resume_In) begin
               state_nxt = SEQ_FETCH;
               halt_nxt  = 1'b0;
            end
         end
         SEQ_TRAP:   state_nxt = SEQ_TRAP;
         default:    state_nxt = SEQ_IDLE;
      endcase

      if (resolve_en) begin
         if (resolve_code == EXCEP_OK) begin
            state_nxt = SEQ_COMMIT;
         end else if (resolve_code == EXCEP_ENV_BREAK) begin
            state_nxt = SEQ_COMMIT;
            halt_nxt  = 1'b1;
         end else begin
            state_nxt = SEQ_TRAP;
            cause_nxt = resolve_code;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= SEQ_IDLE;
         halt_pending   <= 1'b0;
         trapCause_Out  <= EXCEP_OK;
         fetchStart_Out <= 1'b0;
         execEnable_Out <= 1'b0;
         pcCommit_Out   <= 1'b0;
         rdCommit_Out   <= 1'b0;
         execLock_Out   <= 1'b1;
         halted_Out     <= 1'b0;
         trapped_Out    <= 1'b0;
         retired_cnt    <= 32'd0;
         cycles_cnt     <= 32'd0;
      end else begin
         state          <= state_nxt;
         halt_pending   <= halt_nxt;
         trapCause_Out  <= cause_nxt;
         fetchStart_Out <= (state_nxt == SEQ_FETCH) && (state != SEQ_FETCH);
         execEnable_Out <= (state_nxt == SEQ_EXEC) || (state_nxt == SEQ_MEM);
         pcCommit_Out   <= (state_nxt == SEQ_COMMIT);
         rdCommit_Out   <= (state_nxt == SEQ_COMMIT);
         execLock_Out   <= !(state_nxt == SEQ_FETCH || state_nxt == SEQ_EXEC ||
                             state_nxt == SEQ_MEM);
         halted_Out     <= (state_nxt == SEQ_HALT);
         trapped_Out    <= (state_nxt == SEQ_TRAP);
         if (state == SEQ_COMMIT) begin
            retired_cnt <= retired_cnt + 32'd1;
         end
         if (state != SEQ_IDLE && state != SEQ_TRAP) begin
            cycles_cnt <= cycles_cnt + 32'd1;
         end
      end
   end

   assign retired_Out = retired_cnt;
   assign cycles_Out  = cycles_cnt;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a vector table for the normal
// instruction flow plus hand-written trap, timeout, reset and wrap sequences.
module tb_core_sequencer;
   import core_sequencer_pkg::*;

   logic        clk, rst, resume, fetch_done, mem_req, mem_done;
   excep_t      if_exc, id_exc, ex_exc;
   logic        fetch_start, exec_enable, pc_commit, rd_commit, exec_lock, halted, trapped;
   excep_t      trap_cause;
   logic [31:0] retired, cycles;

   int total  = 0;
   int passed = 0;

   // {fetchStart, execEnable, pcCommit, rdCommit, execLock, halted, trapped}
   localparam logic [6:0] O_IDLE = 7'b0000100;
   localparam logic [6:0] O_FST  = 7'b1000000;
   localparam logic [6:0] O_FWT  = 7'b0000000;
   localparam logic [6:0] O_EXM  = 7'b0100000;
   localparam logic [6:0] O_CMT  = 7'b0011100;
   localparam logic [6:0] O_HLT  = 7'b0000110;
   localparam logic [6:0] O_TRP  = 7'b0000101;

   typedef struct {
      logic       fd;
      excep_t     ife;
      excep_t     ide;
      logic       mreq;
      logic       mdone;
      excep_t     exe;
      logic       res;
      logic [6:0] outs;
      int         ret;
   } vec_t;

   vec_t vt[29];

   core_sequencer #(.MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .resume_In      (resume),
      .fetchDone_In   (fetch_done),
      .ifException_In (if_exc),
      .idException_In (id_exc),
      .exMemReq_In    (mem_req),
      .exMemDone_In   (mem_done),
      .exException_In (ex_exc),
      .fetchStart_Out (fetch_start),
      .execEnable_Out (exec_enable),
      .pcCommit_Out   (pc_commit),
      .rdCommit_Out   (rd_commit),
      .execLock_Out   (exec_lock),
      .halted_Out     (halted),
      .trapped_Out    (trapped),
      .trapCause_Out  (trap_cause),
      .retired_Out    (retired),
      .cycles_Out     (cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic fd, input excep_t ife, input excep_t ide,
                                input logic mreq, input logic mdone, input excep_t exe,
                                input logic res, input logic [6:0] outs, input int ret);
      vec_t v;
      v.fd = fd; v.ife = ife; v.ide = ide; v.mreq = mreq; v.mdone = mdone;
      v.exe = exe; v.res = res; v.outs = outs; v.ret = ret;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic set_in(input logic fd, input excep_t ife, input excep_t ide, input logic mreq,
                         input logic mdone, input excep_t exe, input logic res);
      fetch_done = fd; if_exc = ife; id_exc = ide; mem_req = mreq;
      mem_done = mdone; ex_exc = exe; resume = res;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] outs_now();
      return {25'd0, fetch_start, exec_enable, pc_commit, rd_commit, exec_lock, halted, trapped};
   endfunction

   task automatic apply_reset(input string tag);
      rst = 1'b0;
      set_in(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0);
      step();
      check({tag, "_rst_outs"}, outs_now(), {25'd0, O_IDLE});
      check({tag, "_rst_cause"}, trap_cause, EXCEP_OK);
      check({tag, "_rst_retired"}, retired, 32'd0);
      check({tag, "_rst_cycles"}, cycles, 32'd0);
      rst = 1'b1;
   endtask

   initial begin
      vt[0]  = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FST, 0);
      vt[1]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 0);
      vt[2]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_CMT, 0);
      vt[3]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FST, 1);
      vt[4]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 1);
      vt[5]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_CMT, 1);
      vt[6]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FST, 2);
      vt[7]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 2);
      vt[8]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_CMT, 2);
      vt[9]  = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FST, 3);
      vt[10] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 3);
      vt[11] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0, O_EXM, 3);
      vt[12] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0, O_EXM, 3);
      vt[13] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0, O_EXM, 3);
      vt[14] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0, O_EXM, 3);
      vt[15] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 1, EXCEP_OK, 0, O_CMT, 3);
      vt[16] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FST, 4);
      vt[17] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FWT, 4);
      vt[18] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FWT, 4);
      vt[19] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_FWT, 4);
      vt[20] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 4);
      vt[21] = mkv(1, EXCEP_OK, EXCEP_ENV_BREAK, 0, 0, EXCEP_OK, 0, O_CMT, 4);
      vt[22] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 1, EXCEP_OK, 0, O_HLT, 5);
      vt[23] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_HLT, 5);
      vt[24] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 1, O_FST, 5);
      vt[25] = mkv(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0, O_EXM, 5);
      vt[26] = mkv(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_ENV_BREAK, 1, O_CMT, 5);
      vt[27] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 1, O_HLT, 6);
      vt[28] = mkv(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 1, O_FST, 6);

      apply_reset("initial");

      // Normal flow: 3-cycle ALU ops, 4-cycle MEM wait, FETCH wait, env break halts.
      for (int i = 0; i < 29; i++) begin
         set_in(vt[i].fd, vt[i].ife, vt[i].ide, vt[i].mreq, vt[i].mdone, vt[i].exe, vt[i].res);
         step();
         check($sformatf("vec%0d_outs", i), outs_now(), {25'd0, vt[i].outs});
         check($sformatf("vec%0d_retired", i), retired, 32'(vt[i].ret));
         check($sformatf("vec%0d_cause", i), trap_cause, EXCEP_OK);
         if (i == 9) check("three_ops_cycles", cycles, 32'd9);
      end
      check("table_cycles", cycles, 32'd28);

      // Fetch fault outranks a simultaneous execute env break; trap is sticky.
      set_in(1, EXCEP_ILLEGAL_INST, EXCEP_OK, 0, 0, EXCEP_ENV_BREAK, 0);
      step();
      check("if_trap_outs", outs_now(), {25'd0, O_TRP});
      check("if_trap_cause", trap_cause, EXCEP_ILLEGAL_INST);
      set_in(1, EXCEP_OK, EXCEP_OK, 1, 1, EXCEP_OK, 1);
      for (int i = 0; i < 3; i++) step();
      check("trap_sticky_outs", outs_now(), {25'd0, O_TRP});
      check("trap_sticky_cause", trap_cause, EXCEP_ILLEGAL_INST);
      check("trap_retired", retired, 32'd6);
      check("trap_cycles_frozen", cycles, 32'd29);

      // Decode fault outranks execute env break in EXEC.
      apply_reset("id_prio");
      step();
      set_in(1, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0);
      step();
      set_in(0, EXCEP_OK, 4'h7, 1, 0, EXCEP_ENV_BREAK, 0);
      step();
      check("id_trap_outs", outs_now(), {25'd0, O_TRP});
      check("id_trap_cause", trap_cause, 4'h7);

      // MEM never completes: TRAP after exactly four MEM cycles.
      apply_reset("mem_to");
      step();
      set_in(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0);
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("mem_wait%0d_outs", i), outs_now(), {25'd0, O_EXM});
      end
      step();
      check("mem_to_outs", outs_now(), {25'd0, O_TRP});
      check("mem_to_cause", trap_cause, EXCEP_BUS_TIMEOUT);
      check("mem_to_retired", retired, 32'd0);

      // Fetch never completes: same timeout applies in FETCH.
      apply_reset("fetch_to");
      step();
      set_in(0, EXCEP_OK, EXCEP_OK, 0, 0, EXCEP_OK, 0);
      for (int i = 0; i < 3; i++) step();
      check("fetch_wait_outs", outs_now(), {25'd0, O_FWT});
      step();
      check("fetch_to_outs", outs_now(), {25'd0, O_TRP});
      check("fetch_to_cause", trap_cause, EXCEP_BUS_TIMEOUT);

      // Memory-side fault reported with done traps without commit.
      apply_reset("ex_trap");
      step();
      set_in(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0);
      step();
      step();
      set_in(0, EXCEP_OK, EXCEP_OK, 0, 1, 4'h6, 0);
      step();
      check("ex_trap_outs", outs_now(), {25'd0, O_TRP});
      check("ex_trap_cause", trap_cause, 4'h6);

      // Retired counter wraps from all-ones to zero on commit.
      apply_reset("wrap");
      force dut.retired_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retired_cnt;
      check("wrap_preset", retired, 32'hFFFF_FFFF);
      step();
      set_in(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0);
      step();
      step();
      set_in(0, EXCEP_OK, EXCEP_OK, 0, 1, EXCEP_OK, 0);
      step();
      check("wrap_commit_outs", outs_now(), {25'd0, O_CMT});
      step();
      check("wrap_retired", retired, 32'd0);

      // Reset asserted in MEM: outputs return to reset values without a clock edge.
      set_in(1, EXCEP_OK, EXCEP_OK, 1, 0, EXCEP_OK, 0);
      step();
      step();
      check("pre_rst_mem_outs", outs_now(), {25'd0, O_EXM});
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_outs", outs_now(), {25'd0, O_IDLE});
      check("async_rst_retired", retired, 32'd0);
      check("async_rst_cycles", cycles, 32'd0);
      check("async_rst_cause", trap_cause, EXCEP_OK);
      step();
      rst = 1'b1;
      set_in(0, EXCEP_OK, EXCEP_OK, 0, 1, EXCEP_OK, 0);
      step();
      check("post_rst_fetch", outs_now(), {25'd0, O_FST});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the single-issue core. It steps each instruction through fetch, execute, optional data-memory wait and commit, and gates PC and register-file updates. It also merges the fetch, decode and execute exception sources with fixed priority, owns the core execution lock, and provides halt/resume for `EXCEP_ENV_BREAK`. Sits in `Core` between `InstructionFetch`, `Executor`, `RegisterFile` and the memory-access handshakes.

## Interface
- `MEM_TIMEOUT`, default 16: max cycles any fetch or data access may wait for its done strobe before trapping; legal range 2..255.

- `clk` in 1: core clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `resume_In` in 1: level; leave HALT.
- `fetchDone_In` in 1: instruction fetch memory access completed.
- `ifException_In` in `EXCEPTION_LEN`: fetch exception; valid with `fetchDone_In`.
- `idException_In` in `EXCEPTION_LEN`: decode exception; valid in EXEC.
- `exMemReq_In` in 1: current instruction needs a data access; valid in EXEC.
- `exMemDone_In` in 1: data access completed.
- `exException_In` in `EXCEPTION_LEN`: execute/data exception; valid in EXEC and with `exMemDone_In`.
- `fetchStart_Out` out 1: one-cycle request to start a fetch at current PC.
- `execEnable_Out` out 1: high in EXEC and MEM; Executor may drive the memory port.
- `pcCommit_Out` out 1: one-cycle PC update strobe.
- `rdCommit_Out` out 1: one-cycle register write enable gate.
- `execLock_Out` out 1: high in every state except FETCH, EXEC and MEM.
- `halted_Out` out 1: high in HALT.
- `trapped_Out` out 1: high in TRAP.
- `trapCause_Out` out `EXCEPTION_LEN`: captured fatal exception; `EXCEP_OK` otherwise.
- `retired_Out` out 32: committed instruction count.
- `cycles_Out` out 32: count of cycles outside IDLE and TRAP.

## Operation
- States: IDLE, FETCH, EXEC, MEM, COMMIT, HALT, TRAP.
- IDLE: entered only by reset. Moves to FETCH on the next edge.
- FETCH: `fetchStart_Out` is high in its first cycle only.
  - Waits for `fetchDone_In`.
  - On done with `ifException_In != EXCEP_OK`: resolve as below.
  - Otherwise move to EXEC.
- EXEC: one cycle. Evaluates exceptions with priority IF > ID > EX; the first non-`EXCEP_OK` source wins.
  - If no exception: `exMemReq_In` selects MEM, otherwise COMMIT.
- MEM: waits for `exMemDone_In`. `exException_In` is sampled with done, then resolve.
- Resolve:
  - `EXCEP_OK` → COMMIT.
  - `EXCEP_ENV_BREAK` → COMMIT with `halt_pending` set.
  - Any other code → TRAP. `trapCause_Out` latches the code; no commit.
- COMMIT: one cycle.
  - `pcCommit_Out` and `rdCommit_Out` are high; `retired_Out` increments.
  - Next state is HALT if `halt_pending`, else FETCH.
- HALT: `resume_In` high moves to FETCH and clears `halt_pending`.
- TRAP: sticky until `rst`.
- Timeout: a wait counter clears on entry to FETCH and MEM and increments each waiting cycle.
  - If the counter reaches `MEM_TIMEOUT-1` with no done, the block enters TRAP with `EXCEP_BUS_TIMEOUT`.
  - Done in the same cycle as the timeout: done wins.
- Counters wrap modulo 2^32 (0xFFFFFFFF → 0).

## Timing
- Reset values:
  - state IDLE, `halt_pending` 0.
  - `fetchStart_Out`, `execEnable_Out`, `pcCommit_Out`, `rdCommit_Out`, `halted_Out`, `trapped_Out` all 0.
  - `execLock_Out` 1, `trapCause_Out` `EXCEP_OK`, counters 0.
- All outputs are decoded from registered state; no combinational input-to-output path.
- Minimum instruction latency:
  - 3 cycles without memory (FETCH with done in its first cycle, EXEC, COMMIT).
  - 4 cycles with memory.
- Done strobes outside their wait state are ignored.
- Reset asserted mid-operation: immediate return to reset values; no partial commit.
- `resume_In` held high across HALT entry: the block resumes on the first HALT cycle's edge, so HALT lasts exactly 1 cycle.

## Structure
- `constants.v` holds:
  - the state encodings (3-bit `SEQ_*`);
  - the new code `EXCEP_BUS_TIMEOUT`;
  - the existing `EXCEPTION_LEN`, `EXCEP_OK` and `EXCEP_ENV_BREAK`.
- One sub-module, `wait_timer`: parameterised down-counter with clear/enable inputs and an expired output, used for FETCH and MEM.

## Test plan
- Reset release, `fetchDone_In` high every cycle, no exceptions, no memory → one COMMIT every 3 cycles; `retired_Out`=3 after 9 cycles past IDLE.
- EXEC with `exMemReq_In`=1, `exMemDone_In` after 4 MEM cycles → single `rdCommit_Out` pulse on the 6th cycle after fetch start.
- `ifException_In`=illegal and `exException_In`=`EXCEP_ENV_BREAK` together → TRAP, `trapCause_Out`=illegal, no commit pulse.
- `EXCEP_ENV_BREAK` in EXEC → COMMIT, then HALT with `execLock_Out`=1; `resume_In` pulse → `fetchStart_Out` next cycle.
- `MEM_TIMEOUT`=4, `exMemDone_In` never asserted → TRAP with `EXCEP_BUS_TIMEOUT` after 4 MEM cycles; done on the 4th cycle → COMMIT instead.
- `rst` low during MEM → outputs at reset values immediately; `retired_Out` preset to 0xFFFFFFFF via force, then one commit → 0.
